// File: rtl/uart_frame_assembler_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_assembler_if
// Description : Byte-stream bundle between uart_rx, the frame assembler and
//               the solver-side loader. The receive strobe (axiid/axiiv), the
//               payload handshake (axiod/axiov/axiir) and the frame status
//               flags travel together.
//               master : host/loader side (drives bytes in, ready back)
//               slave  : frame assembler
// Revision    : 1.0  initial release
// ============================================================================
interface uart_frame_assembler_if #(
    parameter int MAX_LEN = 64
) ();
    localparam int c_LEN_W = $clog2(MAX_LEN + 1);

    logic [7:0]         axiid;
    logic               axiiv;
    logic [7:0]         axiod;
    logic               axiov;
    logic               axiir;
    logic [c_LEN_W-1:0] frame_len;
    logic               frame_done;
    logic               frame_err;
    logic               overrun;
    logic               busy;

    modport master (
        output axiid, axiiv, axiir,
        input  axiod, axiov, frame_len, frame_done, frame_err, overrun, busy
    );

    modport slave (
        input  axiid, axiiv, axiir,
        output axiod, axiov, frame_len, frame_done, frame_err, overrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_assembler
// Description : Assembles SOF / length / payload / XOR-checksum frames from
//               the uart_rx byte stream, buffers the payload and releases it
//               over a valid/ready byte interface only once the checksum has
//               verified. Rejected frames pulse frame_err and are discarded.
//               Optional macro FRAME_TIMEOUT_EN adds an inter-byte idle
//               timeout (TIMEOUT_CYCLES) that aborts stalled partial frames.
// Revision    : 1.0  initial release
// ============================================================================
module uart_frame_assembler #(
    parameter int         MAX_LEN        = 64,
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50_000_000
) (
    input wire                    clk,
    input wire                    rst,
    uart_frame_assembler_if.slave bus
);
    localparam int c_LEN_W = $clog2(MAX_LEN + 1);
    localparam int c_PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHECK   = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_LEN_W-1:0] r_len;
    logic [c_LEN_W-1:0] r_frame_len;
    logic [7:0]         r_csum;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [7:0]         r_buf [MAX_LEN];
    logic               r_axiov;
    logic               r_frame_done;
    logic               r_frame_err;
    logic               r_overrun;
    logic               r_busy;

    logic [c_LEN_W-1:0] w_len_m1;
    logic               w_len_bad;
    logic               w_wr_last;
    logic               w_rd_last;
    logic               w_xfer;
    logic               w_timeout;

    assign w_len_m1  = r_len - c_LEN_W'(1);
    // A zero length or one that cannot fit the buffer is malformed.
    assign w_len_bad = (bus.axiid == 8'd0) || (int'(bus.axiid) > MAX_LEN);
    assign w_wr_last = (c_LEN_W'(r_wr_ptr) == w_len_m1);
    assign w_rd_last = (c_LEN_W'(r_rd_ptr) == w_len_m1);
    assign w_xfer    = r_axiov && bus.axiir;

`ifdef FRAME_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_TO_W-1:0] r_idle_cnt;
    logic              w_in_frame;

    assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) ||
                        (r_state == S_CHECK);
    assign w_timeout  = w_in_frame && !bus.axiiv &&
                        (r_idle_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: cleared by every received byte and outside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (!w_in_frame || bus.axiiv || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
        end
    end
`else
    // Counter compiled out: constant false for any legal TIMEOUT_CYCLES, so a
    // stalled frame simply waits for more bytes or a reset.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Payload buffer write; no reset needed since reads only follow writes.
    always_ff @(posedge clk) begin
        if ((r_state == S_PAYLOAD) && bus.axiiv) begin
            r_buf[r_wr_ptr] <= bus.axiid;
        end
    end

    // Frame FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_frame_len  <= '0;
            r_csum       <= 8'h00;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_axiov      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.axiiv && (bus.axiid == SOF_BYTE)) begin
                        r_state <= S_LEN;
                        r_busy  <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (bus.axiiv) begin
                        r_len  <= c_LEN_W'(bus.axiid);
                        r_csum <= bus.axiid;
                        if (w_len_bad) begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                        end else begin
                            r_wr_ptr <= '0;
                            r_state  <= S_PAYLOAD;
                        end
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                S_PAYLOAD: begin
                    if (bus.axiiv) begin
                        r_csum   <= r_csum ^ bus.axiid;
                        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                        if (w_wr_last) begin
                            r_state <= S_CHECK;
                        end
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (bus.axiiv) begin
                        if (bus.axiid == r_csum) begin
                            r_rd_ptr    <= '0;
                            r_frame_len <= r_len;
                            r_axiov     <= 1'b1;
                            r_state     <= S_DRAIN;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Bytes arriving now are lost; flag it but keep draining.
                    if (bus.axiiv) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (w_rd_last) begin
                            r_axiov      <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_rd_ptr     <= '0;
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_axiov <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational buffer read keeps axiod aligned with axiov and stable
    // under backpressure since rd_ptr only moves on a transfer.
    assign bus.axiod      = r_axiov ? r_buf[r_rd_ptr] : 8'h00;
    assign bus.axiov      = r_axiov;
    assign bus.frame_len  = r_frame_len;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_assembler
// Description : Self-checking bench for uart_frame_assembler: directed
//               frames (good, bad checksum, bad length, prefix junk,
//               backpressure with overrun, reset mid-frame, idle timeout)
//               followed by randomized frames scored against a frame-level
//               model of the protocol.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_frame_assembler;
    localparam int         MAX_LEN = 64;
    localparam int         TO      = 100;
    localparam logic [7:0] SOF     = 8'hA5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_frame_assembler_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_frame_assembler #(
        .MAX_LEN        (MAX_LEN),
        .SOF_BYTE       (SOF),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    int         n_done;
    int         n_err;
    int         ready_mode;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         e_done;
    int         e_err;
    int         e_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: set ready, capture the transfer, advance, check hold rules.
    task automatic tick();
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        case (ready_mode)
            0:       bus.axiir = 1'b1;
            1:       bus.axiir = 1'($urandom_range(0, 1));
            default: bus.axiir = ~bus.axiir;
        endcase
        pv = bus.axiov;
        pr = bus.axiir;
        pd = bus.axiod;
        if (pv && pr) rx_q.push_back(pd);
        @(posedge clk);
        #1;
        if (bus.frame_done) n_done++;
        if (bus.frame_err)  n_err++;
        chk("done_err_exclusive", 32'(bus.frame_done & bus.frame_err), 32'd0);
        if (pv && !pr) begin
            chk("hold_axiov", 32'(bus.axiov), 32'd1);
            chk("hold_axiod", 32'(bus.axiod), 32'(pd));
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.axiid = b;
        bus.axiiv = 1'b1;
        tick();
        bus.axiiv = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_axiod"},      32'(bus.axiod),      32'd0);
        chk({tag, "_axiov"},      32'(bus.axiov),      32'd0);
        chk({tag, "_frame_len"},  32'(bus.frame_len),  32'd0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        chk({tag, "_frame_err"},  32'(bus.frame_err),  32'd0);
        chk({tag, "_overrun"},    32'(bus.overrun),    32'd0);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    endtask

    // Protocol model: skip to SOF, validate length, XOR(len, payload) must
    // equal the trailing byte for the payload to be released.
    task automatic model(input logic [7:0] f[$]);
        int         k;
        int         len;
        logic [7:0] x;
        exp_q.delete();
        e_done = 0;
        e_err  = 0;
        e_len  = 0;
        k = -1;
        for (int i = 0; i < f.size(); i++) begin
            if (k < 0 && f[i] == SOF) k = i;
        end
        if (k < 0 || k + 1 >= f.size()) return;
        len = int'(f[k+1]);
        if (len == 0 || len > MAX_LEN) begin
            e_err = 1;
            return;
        end
        x = f[k+1];
        for (int i = 0; i < len; i++) x = x ^ f[k+2+i];
        if (x == f[k+2+len]) begin
            for (int i = 0; i < len; i++) exp_q.push_back(f[k+2+i]);
            e_done = 1;
            e_len  = len;
        end else begin
            e_err = 1;
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] f[$],
                             input int gap_max, input bit inject);
        int cnt;
        int bad;
        bit injected;
        rx_q.delete();
        n_done = 0;
        n_err  = 0;
        model(f);
        foreach (f[i]) begin
            send(f[i]);
            repeat ($urandom_range(0, gap_max)) tick();
        end
        cnt      = 0;
        injected = 1'b0;
        while ((bus.busy || bus.axiov) && cnt < 2000) begin
            if (inject && bus.axiov && !injected) begin
                injected = 1'b1;
                send(8'($urandom));
            end else begin
                tick();
            end
            cnt++;
        end
        chk({tag, "_drain_bound"}, 32'(cnt < 2000), 32'd1);
        tick();
        tick();
        chk({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        bad = 0;
        foreach (exp_q[i]) begin
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
        end
        chk({tag, "_rx_data"},    32'(bad),    32'd0);
        chk({tag, "_done_count"}, 32'(n_done), 32'(e_done));
        chk({tag, "_err_count"},  32'(n_err),  32'(e_err));
        if (e_done != 0) chk({tag, "_frame_len"}, 32'(bus.frame_len), 32'(e_len));
        if (inject) chk({tag, "_overrun_injected"}, 32'(injected), 32'd1);
    endtask

    // Hang guard: every wait is bounded, this only catches a broken bench.
    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] f[$];
        logic [7:0] x;
        int         len;
        int         kind;

        rst        = 1'b1;
        bus.axiid  = 8'h00;
        bus.axiiv  = 1'b0;
        bus.axiir  = 1'b1;
        ready_mode = 0;
        n_done     = 0;
        n_err      = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Good frame, ready held high: one byte per cycle after the checksum.
        rx_q.delete();
        n_done = 0;
        n_err  = 0;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h03);
        chk("good_axiov_first", 32'(bus.axiov),     32'd1);
        chk("good_byte0",       32'(bus.axiod),     32'h11);
        chk("good_frame_len",   32'(bus.frame_len), 32'd3);
        tick();
        chk("good_byte1", 32'(bus.axiod), 32'h22);
        tick();
        chk("good_byte2", 32'(bus.axiod), 32'h33);
        tick();
        chk("good_axiov_drop",  32'(bus.axiov),      32'd0);
        chk("good_frame_done",  32'(bus.frame_done), 32'd1);
        chk("good_busy_low",    32'(bus.busy),       32'd0);
        tick();
        chk("good_done_once",   32'(n_done),         32'd1);
        chk("good_no_err",      32'(n_err),          32'd0);
        chk("good_rx_count",    32'(rx_q.size()),    32'd3);

        // Bad checksum: rejected, nothing released.
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        send(8'h04);
        chk("badcs_err_pulse", 32'(bus.frame_err), 32'd1);
        chk("badcs_axiov",     32'(bus.axiov),     32'd0);
        tick();
        chk("badcs_err_single", 32'(bus.frame_err), 32'd0);
        chk("badcs_busy",       32'(bus.busy),      32'd0);
        f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        run_frame("after_badcs", f, 0, 1'b0);

        // Bad lengths.
        send(8'hA5); send(8'h00);
        chk("len0_err",  32'(bus.frame_err), 32'd1);
        chk("len0_busy", 32'(bus.busy),      32'd0);
        tick();
        send(8'hA5); send(8'h41);
        chk("len65_err",  32'(bus.frame_err), 32'd1);
        chk("len65_busy", 32'(bus.busy),      32'd0);
        tick();

        // Junk before SOF is ignored; SOF inside the payload is plain data.
        f = '{8'h12, 8'h55, 8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64};
        run_frame("prefix", f, 0, 1'b0);
        f = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
        run_frame("sof_in_payload", f, 1, 1'b0);

        // Randomized frames with random gaps and random ready.
        for (int n = 0; n < 40; n++) begin
            ready_mode = 1;
            f.delete();
            repeat ($urandom_range(0, 3)) begin
                x = 8'($urandom);
                if (x == SOF) x = 8'h00;
                f.push_back(x);
            end
            f.push_back(SOF);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                f.push_back(($urandom_range(0, 1) == 0) ? 8'h00
                                                        : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                len = (kind == 1) ? 1 : (kind == 2) ? MAX_LEN : $urandom_range(1, MAX_LEN);
                f.push_back(8'(len));
                x = 8'(len);
                for (int i = 0; i < len; i++) begin
                    f.push_back(8'($urandom));
                    x = x ^ f[f.size()-1];
                end
                if (kind == 3) x = x ^ (8'h01 << $urandom_range(0, 7));
                f.push_back(x);
            end
            run_frame("random", f, 3, 1'b0);
        end

        // Backpressure with toggling ready plus a strobe during the drain.
        ready_mode = 0;
        chk("overrun_clear_before", 32'(bus.overrun), 32'd0);
        ready_mode = 2;
        bus.axiir  = 1'b1;
        f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        run_frame("backpressure", f, 0, 1'b1);
        chk("overrun_set", 32'(bus.overrun), 32'd1);
        ready_mode = 0;

        // Reset mid-frame drops the partial frame silently.
        n_err = 0;
        send(8'hA5); send(8'h03); send(8'h11);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) tick();
        chk("midrst_no_err", 32'(n_err), 32'd0);
        f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        run_frame("after_midrst", f, 0, 1'b0);

        // Stalled partial frame.
        n_err = 0;
        send(8'hA5); send(8'h03); send(8'h11);
        repeat (120) tick();
`ifdef FRAME_TIMEOUT_EN
        chk("timeout_err",  32'(n_err),    32'd1);
        chk("timeout_busy", 32'(bus.busy), 32'd0);
`else
        chk("stall_busy",   32'(bus.busy), 32'd1);
        chk("stall_no_err", 32'(n_err),    32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
`endif
        f = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        run_frame("after_stall", f, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_assembler.md
Name: uart_frame_assembler

Overview:
- Sits directly downstream of uart_rx. Consumes its byte stream (axiod/axiov) and assembles framed host packets: SOF, length, payload, XOR checksum.
- Buffers the payload internally. Releases it to the solver-side loader only after the checksum verifies.
- Releases payload over a valid/ready byte interface. Corrupt or malformed frames never reach the solver.

Parameters:
- MAX_LEN, 64, maximum payload bytes per frame; buffer depth.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYCLES, 50_000_000, inter-byte idle limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset, asynchronous, active-high
- axiid  in  8  received byte from uart_rx
- axiiv  in  1  single-cycle strobe; axiid is valid this cycle
- axiod  out  8  payload byte to downstream
- axiov  out  1  axiod valid
- axiir  in  1  downstream ready; byte transfers when axiov && axiir
- frame_len  out  $clog2(MAX_LEN+1)  length of the frame being drained
- frame_done  out  1  one-cycle pulse after the last payload byte transfers
- frame_err  out  1  one-cycle pulse on any rejected frame
- overrun  out  1  sticky; a byte arrived while draining; cleared only by rst
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: state=IDLE; axiod=0; axiov=0; frame_len=0; frame_done=0; frame_err=0; overrun=0; busy=0. All pointers and the checksum register are 0.
- Asserting rst mid-frame discards the partial frame immediately. No frame_err is generated.
- IDLE:
  - On axiiv with axiid==SOF_BYTE: go to LEN.
  - All other bytes are ignored silently.
- LEN:
  - On axiiv: latch len=axiid and set csum=axiid.
  - If len==0 or len>MAX_LEN: pulse frame_err next cycle and go to IDLE.
  - Otherwise: set wr_ptr=0 and go to PAYLOAD.
- PAYLOAD:
  - On axiiv: buf[wr_ptr]<=axiid, csum<=csum^axiid, wr_ptr++.
  - When the byte written is number len: go to CHECK.
- CHECK:
  - On axiiv: compare axiid against csum in the same cycle.
  - On match: go to DRAIN with rd_ptr=0 and frame_len=len. axiov rises the cycle after the checksum strobe.
  - On mismatch: pulse frame_err next cycle and go to IDLE.
- DRAIN:
  - axiov=1 and axiod=buf[rd_ptr].
  - On axiov&&axiir: rd_ptr++. When the transferred byte is the last (rd_ptr==len-1): axiov drops next cycle, frame_done pulses that same cycle, and state goes to IDLE.
  - axiod must hold stable while axiov && !axiir.
  - Any axiiv during DRAIN: byte dropped, overrun<=1, drain continues unaffected.
- Throughput: with axiir held high, one byte transfers per cycle.
- SOF_BYTE inside LEN/PAYLOAD/CHECK is treated as ordinary data. There is no resync mid-frame.
- frame_done and frame_err are never asserted in the same cycle.
- Buffer is a simple register or distributed RAM array. The read is combinational from rd_ptr so axiod is valid whenever axiov is high.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- Defined:
  - An idle counter resets on every axiiv and counts while state is LEN, PAYLOAD or CHECK.
  - When it reaches TIMEOUT_CYCLES-1, pulse frame_err next cycle and return to IDLE.
  - The counter is held at 0 in IDLE and DRAIN.
- Undefined:
  - No counter logic is present. A stalled partial frame waits indefinitely until rst or more bytes arrive.

Test Plan:
- Good frame with axiir=1: strobes A5,03,11,22,33,03 -> axiod 11,22,33 on three consecutive cycles starting the cycle after the checksum strobe. Then frame_done pulses once, frame_len=3, frame_err never asserts.
- Bad checksum: A5,03,11,22,33,04 -> frame_err pulses once, axiov stays 0, state returns to IDLE. A following good frame is accepted.
- Bad length: A5,00 -> frame_err. A5,41 with MAX_LEN=64 -> frame_err. Bytes before SOF (e.g. 55,A5 preceded by 12) are ignored.
- Backpressure plus overrun: good 3-byte frame with axiir toggling 0/1 -> each byte is held stable until accepted, order 11,22,33 is preserved. An axiiv strobe during DRAIN sets overrun=1 and output is unchanged.
- Reset mid-frame: A5,03,11 then rst pulse -> all outputs at reset values, no frame_err. A subsequent full good frame drains correctly.
- With FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=100: A5,03,11 then 100 idle cycles -> frame_err pulses and busy falls. Without the macro: busy stays high.
